// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Brief    : Registered WIDTH-bit RISC-V execute-stage ALU with zero flag.
//            Optional carry/overflow/negative outputs with macro ALU_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ScrA,
  input  logic [WIDTH-1:0] ScrB,
  input  logic [2:0]       AluControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow,
  output logic             negative
`endif
);

  localparam int c_SHW = $clog2(WIDTH);
`ifdef ALU_FLAGS_EN
  localparam int c_EXT = 1;
`else
  localparam int c_EXT = 0;
`endif
  // One extra bit on the adder/subtractor only when carry is exported.
  localparam int c_XW  = WIDTH + c_EXT;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_SRL = 3'b101;
  localparam logic [2:0] c_OP_SLL = 3'b110;
  localparam logic [2:0] c_OP_SLT = 3'b111;

  logic [c_XW-1:0]  w_a_x;
  logic [c_XW-1:0]  w_b_x;
  logic [c_XW-1:0]  w_sum;
  logic [c_XW-1:0]  w_diff;
  logic [c_SHW-1:0] w_shamt;
  logic             w_msb_a;
  logic             w_msb_b;
  logic             w_ovf_add;
  logic             w_ovf_sub;
  logic             w_slt;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;

  assign w_a_x   = c_XW'(ScrA);
  assign w_b_x   = c_XW'(ScrB);
  assign w_sum   = w_a_x + w_b_x;
  assign w_diff  = w_a_x - w_b_x;
  assign w_shamt = ScrB[c_SHW-1:0];
  assign w_msb_a = ScrA[WIDTH-1];
  assign w_msb_b = ScrB[WIDTH-1];

  assign w_ovf_add = (w_msb_a == w_msb_b) && (w_sum[WIDTH-1]  != w_msb_a);
  assign w_ovf_sub = (w_msb_a != w_msb_b) && (w_diff[WIDTH-1] != w_msb_a);
  // Sign of the shared difference corrected by overflow gives signed less-than.
  assign w_slt     = w_diff[WIDTH-1] ^ w_ovf_sub;

  always_comb begin
    w_result = '0;
    case (AluControl)
      c_OP_ADD: w_result = w_sum[WIDTH-1:0];
      c_OP_SUB: w_result = w_diff[WIDTH-1:0];
      c_OP_AND: w_result = ScrA & ScrB;
      c_OP_OR:  w_result = ScrA | ScrB;
      c_OP_XOR: w_result = ScrA ^ ScrB;
      c_OP_SRL: w_result = ScrA >> w_shamt;
      c_OP_SLL: w_result = ScrA << w_shamt;
      c_OP_SLT: w_result = {{(WIDTH-1){1'b0}}, w_slt};
      default:  w_result = '0;
    endcase
  end

  assign w_zero = (w_result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult <= '0;
      zero      <= 1'b1;
    end else begin
      ALUResult <= w_result;
      zero      <= w_zero;
    end
  end

`ifdef ALU_FLAGS_EN
  logic w_carry;
  logic w_overflow;

  // Carry is NOT borrow for subtract-based ops.
  always_comb begin
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (AluControl)
      c_OP_ADD: begin
        w_carry    = w_sum[WIDTH];
        w_overflow = w_ovf_add;
      end
      c_OP_SUB: begin
        w_carry    = ~w_diff[WIDTH];
        w_overflow = w_ovf_sub;
      end
      c_OP_SLT: w_carry = ~w_diff[WIDTH];
      default: begin
        w_carry    = 1'b0;
        w_overflow = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry    <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
    end else begin
      carry    <= w_carry;
      overflow <= w_overflow;
      negative <= w_result[WIDTH-1];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module   : tb_alu
// Brief    : Scoreboard testbench for alu; flags checked when ALU_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic        cf;
    logic        vf;
    logic        nf;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic [31:0] alu_res;
  logic        alu_zero;
`ifdef ALU_FLAGS_EN
  logic        alu_carry;
  logic        alu_ovf;
  logic        alu_neg;
`endif

  int n_total = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ScrA       (a),
    .ScrB       (b),
    .AluControl (op),
    .ALUResult  (alu_res),
    .zero       (alu_zero)
`ifdef ALU_FLAGS_EN
    ,
    .carry      (alu_carry),
    .overflow   (alu_ovf),
    .negative   (alu_neg)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [2:0] c, input string tag);
    exp_t   e;
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint t;
    int     sh = int'(y % 32);
    e.cf = 1'b0;
    e.vf = 1'b0;
    e.tag = tag;
    case (c)
      3'd0: begin
        t = ux + uy; e.res = t[31:0]; e.cf = (t >= 64'sh1_0000_0000);
        t = sx + sy; e.vf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd1: begin
        t = ux - uy; e.res = t[31:0]; e.cf = (ux >= uy);
        t = sx - sy; e.vf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = x >> sh;
      3'd6: e.res = x << sh;
      default: begin
        e.res = (sx < sy) ? 32'd1 : 32'd0;
        e.cf  = (ux >= uy);
      end
    endcase
    e.zf = (e.res == 32'd0);
    e.nf = e.res[31];
    return e;
  endfunction

  // Drive away from the sampling edge; expectation is due at the next posedge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] c, input string tag);
    @(negedge clk);
    a = x; b = y; op = c;
    exp_q.push_back(model(x, y, c, tag));
  endtask

  // Monitor: one result per edge, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".res"},  alu_res, e.res);
        chk({e.tag, ".zero"}, {31'b0, alu_zero}, {31'b0, e.zf});
`ifdef ALU_FLAGS_EN
        chk({e.tag, ".carry"}, {31'b0, alu_carry}, {31'b0, e.cf});
        chk({e.tag, ".ovf"},   {31'b0, alu_ovf},   {31'b0, e.vf});
        chk({e.tag, ".neg"},   {31'b0, alu_neg},   {31'b0, e.nf});
`endif
      end
    end
  end

  initial begin
    logic [31:0] x, y;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.res",  alu_res, 32'd0);
    chk("rst.zero", {31'b0, alu_zero}, 32'd1);
    rst_n = 1'b1;

    issue(32'h0000AAAA, 32'h00005555, 3'd0, "add");
    issue(32'h0000AAAA, 32'h00005555, 3'd1, "sub");
    issue(32'h00001234, 32'h00001234, 3'd1, "sub_eq");

    // Mid-run reset: in-flight result dropped, outputs hold until next edge.
    issue(32'h0000AAAA, 32'h00005555, 3'd3, "inflight");
    @(posedge clk);
    #2;
    void'(exp_q.pop_front());
    a = 32'hFFFF0000; b = 32'h0000FFFF; op = 3'd3;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.res",  alu_res, 32'd0);
    chk("midrst.zero", {31'b0, alu_zero}, 32'd1);
    #1 rst_n = 1'b1;
    #1;
    chk("release.res",  alu_res, 32'd0);
    chk("release.zero", {31'b0, alu_zero}, 32'd1);
    exp_q.push_back(model(a, b, op, "first_post_rst"));

    issue(32'd2,        32'd3,        3'd2, "and");
    issue(32'h0000AAAA, 32'h00005555, 3'd3, "or");
    issue(32'h0000AAAA, 32'h00005555, 3'd4, "xor");
    issue(32'h0000AAAA, 32'h00005555, 3'd2, "and_zero");
    issue(32'h0000AAAA, 32'h00005555, 3'd5, "srl21");
    issue(32'd3,        32'd2,        3'd6, "sll");
    issue(32'd1,        32'h00000020, 3'd6, "sll0");
    issue(32'd1,        32'd31,       3'd6, "sll31");
    issue(32'h80000000, 32'd31,       3'd5, "srl31");
    issue(32'd2,        32'd3,        3'd7, "slt_lt");
    issue(32'd3,        32'd2,        3'd7, "slt_gt");
    issue(32'h80000000, 32'd1,        3'd7, "slt_min");
    issue(32'h7FFFFFFF, 32'h80000000, 3'd7, "slt_max");
    issue(32'hFFFFFFFF, 32'd1,        3'd0, "add_wrap");
    issue(32'h7FFFFFFF, 32'd1,        3'd0, "add_ovf");
    issue(32'h80000000, 32'd1,        3'd1, "sub_ovf");

    for (int k = 0; k < 8; k++)
      issue(32'h9ABC_DEF0, 32'h1234_5673, 3'(k), $sformatf("b2b%0d", k));

    for (int i = 0; i < 400; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: x = 32'h80000000;
        1: y = 32'h7FFFFFFF;
        2: y = x;
        default: ;
      endcase
      issue(x, y, 3'($urandom_range(0, 7)), $sformatf("rnd%0d", i));
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/alu.md
Name: alu

Overview:
- Registered 32-bit integer ALU for the RISC-V datapath execute stage.
- Combinationally computes one of eight operations on ScrA/ScrB, selected by AluControl.
- Captures the result and a zero flag in output registers on the rising clock edge.
- The zero flag drives branch decisions (BEQ/BNE) in the control unit.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 8 and a power of two. Shift amount width is log2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- ScrA  input  WIDTH  operand A (rs1 / PC)
- ScrB  input  WIDTH  operand B (rs2 / immediate)
- AluControl  input  3  operation select
- ALUResult  output  WIDTH  registered operation result
- zero  output  1  registered flag, 1 when the registered ALUResult is all zeros

Behaviour:
- Reset: while rst_n is low, asynchronously and immediately ALUResult=0 and zero=1. Outputs hold through reset release until the first rising clk edge.
- Latency: 1 cycle. Inputs are sampled at a rising clk edge; ALUResult and zero reflect them after that edge. No enable: the registers update on every edge.
- Operation decode (AluControl):
  - 000 ADD: A+B, modulo 2^WIDTH, carry discarded.
  - 001 SUB: A-B, two's complement, modulo 2^WIDTH.
  - 010 AND: A&B, bitwise.
  - 011 OR: A|B, bitwise.
  - 100 XOR: A^B, bitwise.
  - 101 SRL: A logically shifted right by B[log2(WIDTH)-1:0]; upper bits of B ignored; zero fill.
  - 110 SLL: A shifted left by B[log2(WIDTH)-1:0]; upper bits of B ignored.
  - 111 SLT: result is 1 if A<B as signed two's complement, else 0 (bits WIDTH-1:1 are zero).
- SUB and SLT share one subtractor. SLT = sign(A-B) XOR signed-overflow(A-B), which gives a correct result at the extremes.
- zero is computed from the next-state result and registered alongside it, so zero always matches the registered ALUResult.
- Shift by 0 returns A unchanged. Shift by WIDTH-1 is legal.
- Reset asserted mid-operation discards the in-flight result. The first post-reset edge loads the result of whatever inputs are present at that edge.
- Inputs containing X/Z: no requirement.

Optional Feature:
- ALU_FLAGS_EN: when defined, adds three registered outputs, each 1 bit and each 0 on reset, updated on the same edge as ALUResult:
  - carry: carry-out for ADD; NOT borrow for SUB/SLT; 0 for all other ops.
  - overflow: signed overflow for ADD/SUB; 0 for all other ops.
  - negative: equals ALUResult[WIDTH-1].
- When not defined, these ports and registers do not exist, and the interface is exactly the port list above.

Test Plan:
- Reset and ADD/SUB:
  - Assert rst_n=0 mid-run, then release -> ALUResult=0 and zero=1 immediately; both hold until the next clk edge.
  - ADD: A=0x0000AAAA, B=0x00005555, ctl=000 -> next edge ALUResult=0x0000FFFF, zero=0.
  - SUB: same operands, ctl=001 -> 0x00005555.
  - SUB: A=B=0x1234 -> 0, zero=1.
- Logic ops:
  - AND: A=2, B=3, ctl=010 -> 2.
  - OR: A=0xAAAA, B=0x5555, ctl=011 -> 0xFFFF.
  - XOR: A=0xAAAA, B=0x5555, ctl=100 -> 0xFFFF.
  - AND: A=0xAAAA, B=0x5555 -> 0, zero=1.
- Shifts:
  - SRL: A=0xAAAA, B=0x5555, ctl=101 (shamt 21) -> 0, zero=1.
  - SLL: A=3, B=2, ctl=110 -> 12.
  - SLL: A=1, B=0x20 (shamt 0) -> 1.
  - SLL: A=1, B=31 -> 0x80000000.
- SLT:
  - A=2, B=3, ctl=111 -> 1.
  - A=3, B=2 -> 0, zero=1.
  - A=0x80000000, B=1 -> 1.
  - A=0x7FFFFFFF, B=0x80000000 -> 0.
- Wrap and flags (ALU_FLAGS_EN defined):
  - ADD: 0xFFFFFFFF+1 -> ALUResult=0, zero=1, carry=1, overflow=0.
  - ADD: 0x7FFFFFFF+1 -> 0x80000000, overflow=1, negative=1.
- Back-to-back: change ctl every cycle through all eight codes -> each result appears exactly one edge after its inputs, with no skipped or duplicated results.
